// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART constants and transmit FSM encoding.
// The receive path imports the same frame constants so both ends agree on framing.
package uart_tx_fifo_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int DATA_BITS     = 8;
    localparam int TICKS_PER_BIT = 16;
    localparam int BAUD_SEL_W    = 3;

    localparam int TICK_CNT_W = $clog2(TICKS_PER_BIT);
    localparam int BIT_CNT_W  = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Bits needed to hold base_div shifted left by the largest baud_sel value.
    function automatic int div_width(input int base_div);
        return $clog2(base_div) + (1 << BAUD_SEL_W);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// Transmit FIFO (module tx_fifo): power-of-two depth, occupancy counter drives full/empty.
// Read data is presented combinationally from the head entry so a pop can load it the same cycle.
module tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; zeroed pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: baud16x divider, 4-state frame FSM, registered line output.
// Frames run back to back while the FIFO has data; Int_T marks the final cycle of every stop bit.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int BASE_DIV   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BAUD_SEL_W-1:0]  baud_sel,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   data_out,
    output logic                   busy,
    output logic                   Int_T
);

    localparam int DIV_W = div_width(BASE_DIV);

    tx_state_e              state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [BAUD_SEL_W-1:0]  sel_q, sel_d;
    logic [TICK_CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic                   data_out_q, data_out_d;
    logic                   overflow_q, overflow_d;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_rd_data;
    logic                   pop;
    logic                   start_frame;
    logic                   int_t;
    logic [DIV_W-1:0]       div_last;
    logic                   tick;
    logic                   bit_done;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Divisor uses the baud_sel captured at frame start, so mid-frame changes have no effect.
    assign div_last = (DIV_W'(BASE_DIV) << sel_q) - DIV_W'(1);
    assign tick     = (div_q == div_last);
    assign bit_done = tick && (tick_cnt_q == TICK_CNT_W'(TICKS_PER_BIT - 1));

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        sel_d       = sel_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        data_out_d  = data_out_q;
        start_frame = 1'b0;
        int_t       = 1'b0;
        pop         = 1'b0;

        if (state_q != ST_IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                start_frame = !fifo_empty;
            end
            ST_START: begin
                if (bit_done) begin
                    state_d    = ST_DATA;
                    bit_cnt_d  = '0;
                    data_out_d = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        state_d    = ST_STOP;
                        data_out_d = 1'b1;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
                        shreg_d    = shreg_q >> 1;
                        data_out_d = shreg_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    int_t = 1'b1;
                    if (fifo_empty) begin
                        state_d = ST_IDLE;
                    end else begin
                        start_frame = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Entering START: pop the head byte, restart bit timing and latch the baud select.
        if (start_frame) begin
            pop        = 1'b1;
            state_d    = ST_START;
            div_d      = '0;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            shreg_d    = fifo_rd_data;
            sel_d      = baud_sel;
            data_out_d = 1'b0;
        end

        overflow_d = overflow_q | (wr_en & fifo_full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            sel_q      <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_out_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            sel_q      <= sel_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
            overflow_q <= overflow_d;
        end
    end

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_q;
    assign data_out = data_out_q;
    assign busy     = (state_q != ST_IDLE);
    assign Int_T    = int_t;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame timing, back-to-back frames, overflow, baud latching, reset abort.
// Expected line levels are built from the byte value and the bit period the bench chooses.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] baud_sel;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       data_out;
    logic       busy;
    logic       int_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .BASE_DIV   (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_sel (baud_sel),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .data_out (data_out),
        .busy     (busy),
        .Int_T    (int_t)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walks one frame from its first start-bit cycle (or from cycle 'skip' of it),
    // checking line level, busy and Int_T every clock; drops wr_en after the first step.
    task automatic check_frame(input logic [7:0] b, input int cpb, input int skip);
        for (int idx = skip; idx < 10 * cpb; idx++) begin
            int   bi;
            logic eb;
            bi = idx / cpb;
            if (bi == 0)      eb = 1'b0;
            else if (bi == 9) eb = 1'b1;
            else              eb = b[bi-1];
            check($sformatf("frame %02h bit %0d data_out", b, bi), data_out, eb);
            check($sformatf("frame %02h busy", b), busy, 1);
            check($sformatf("frame %02h Int_T cycle %0d", b, idx), int_t, (idx == 10 * cpb - 1) ? 1 : 0);
            step();
            wr_en = 1'b0;
        end
    endtask

    logic [7:0] burst [6];

    initial begin
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rst      = 1'b1;
        baud_sel = 3'd0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        #2;
        rst = 1'b0;
        #1;
        check("reset data_out", data_out, 1);
        check("reset busy", busy, 0);
        check("reset Int_T", int_t, 0);
        check("reset full", full, 0);
        check("reset empty", empty, 1);
        check("reset overflow", overflow, 0);
        repeat (3) step();
        rst = 1'b1;
        repeat (3) step();

        // Single byte 0xA5: start at N+2, Int_T at N+161, idle at N+162.
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        check("A5 N+1 empty", empty, 0);
        check("A5 N+1 busy", busy, 0);
        check("A5 N+1 data_out", data_out, 1);
        step();
        check("A5 N+2 empty after pop", empty, 1);
        check_frame(8'hA5, 16, 0);
        check("A5 end busy", busy, 0);
        check("A5 end data_out", data_out, 1);
        check("A5 end Int_T", int_t, 0);
        repeat (5) step();

        // Three bytes in consecutive cycles: contiguous frames, no idle gap.
        wr_en   = 1'b1;
        wr_data = 8'h00;
        step();
        wr_data = 8'hFF;
        step();
        wr_data = 8'h3C;
        check_frame(8'h00, 16, 0);
        check("b2b empty after 2nd pop", empty, 0);
        check_frame(8'hFF, 16, 0);
        check("b2b empty after 3rd pop", empty, 1);
        check_frame(8'h3C, 16, 0);
        check("b2b end busy", busy, 0);
        check("b2b overflow", overflow, 0);
        repeat (5) step();

        // Six bytes into a depth-4 FIFO: one popped, four buffered, sixth dropped.
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = burst[i];
            step();
        end
        wr_en = 1'b0;
        check("burst full", full, 1);
        check("burst overflow", overflow, 1);
        check("burst empty", empty, 0);
        check_frame(8'h11, 16, 4);
        check("burst full after 2nd pop", full, 0);
        check_frame(8'h22, 16, 0);
        check_frame(8'h33, 16, 0);
        check_frame(8'h44, 16, 0);
        check("burst empty before last frame", empty, 1);
        check_frame(8'h55, 16, 0);
        check("burst only five frames", busy, 0);
        check("burst overflow sticky", overflow, 1);
        repeat (5) step();

        // baud_sel=2 latched at pop, changed to 0 mid-frame: 64 clk bits, then 16 clk bits.
        baud_sel = 3'd2;
        wr_en    = 1'b1;
        wr_data  = 8'h5A;
        step();
        wr_data = 8'hC3;
        check("baud N+1 busy", busy, 0);
        step();
        wr_en    = 1'b0;
        baud_sel = 3'd0;
        check_frame(8'h5A, 64, 0);
        check_frame(8'hC3, 16, 0);
        check("baud end busy", busy, 0);
        repeat (5) step();

        // Reset during data bit 3 with two bytes still queued.
        wr_en   = 1'b1;
        wr_data = 8'hA1;
        step();
        wr_data = 8'hB2;
        step();
        wr_data = 8'hC3;
        step();
        wr_en = 1'b0;
        repeat (69) step();
        check("pre-reset data bit 3", data_out, 0);
        check("pre-reset busy", busy, 1);
        check("pre-reset empty", empty, 0);
        rst = 1'b0;
        #1;
        check("abort data_out", data_out, 1);
        check("abort busy", busy, 0);
        check("abort empty", empty, 1);
        check("abort full", full, 0);
        check("abort overflow", overflow, 0);
        check("abort Int_T", int_t, 0);
        repeat (3) step();
        rst = 1'b1;
        for (int c = 0; c < 300; c++) begin
            step();
            check("post-reset data_out", data_out, 1);
            check("post-reset busy", busy, 0);
            check("post-reset Int_T", int_t, 0);
        end
        check("post-reset empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
